// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - switch to 7-segment display controller (hex / complement / signed decimal), option LZ_BLANK_EN
// Optional build macro: LZ_BLANK_EN blanks leading zero nibbles in HEX mode (digit 0 always shown).
module hex_display_ctrl #(
  parameter int W          = 10,
  parameter int NDIG       = 6,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      sw,
  input  logic              key_mode,
  output logic [W-1:0]      ledr,
  output logic [7*NDIG-1:0] hex,
  output logic [1:0]        mode,
  output logic              busy
);

  localparam int NHEX = (W + 3) / 4;
  localparam int ND   = NDIG - 1;
  localparam int BW   = 4 * ND;
  localparam int DCW  = $clog2(DEB_CYCLES + 1);
  localparam int BCW  = $clog2(W + 1);

  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(W - 1);
  localparam logic [W-1:0]   ONE_W    = W'(1);

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_MINUS = 7'h3F;
  localparam logic [6:0] G_F     = 7'h0E;

  localparam logic [1:0] MODE_HEX  = 2'd0;
  localparam logic [1:0] MODE_COMP = 2'd1;
  localparam logic [1:0] MODE_DEC  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [W-1:0]        sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic                key_meta_q, key_meta_d, key_sync_q, key_sync_d;
  logic                key_prev_q, key_prev_d, key_db_q, key_db_d;
  logic [DCW-1:0]      deb_cnt_q, deb_cnt_d;
  logic [W-1:0]        ledr_q, ledr_d;
  logic [1:0]          mode_q, mode_d, last_mode_q, last_mode_d;
  logic [W-1:0]        last_val_q, last_val_d, val_q, val_d;
  logic                dirty_q, dirty_d, neg_q, neg_d, busy_q, busy_d;
  logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [7*NDIG-1:0]   hex_q, hex_d, disp_glyphs;
  logic [4*NHEX-1:0]   padv;
  logic [4*NDIG-1:0]   bcdp;
  logic [NDIG-1:0]     dec_nz, dec_show;
`ifdef LZ_BLANK_EN
  logic [NHEX-1:0]     hex_nz;
`endif

  // Glyph image the next DONE will latch, built from the captured mode and converted value
  always_comb begin
    disp_glyphs = {NDIG{G_BLANK}};
    padv = '0;
    padv[W-1:0] = val_q;
    bcdp = '0;
    bcdp[BW-1:0] = bcd_q;
    dec_nz[NDIG-1] = (bcdp[4*(NDIG-1) +: 4] != 4'd0);
    for (int i = NDIG - 2; i >= 0; i--) begin
      dec_nz[i] = dec_nz[i+1] | (bcdp[4*i +: 4] != 4'd0);
    end
    dec_show = dec_nz | {{(NDIG-1){1'b0}}, 1'b1};
`ifdef LZ_BLANK_EN
    hex_nz[NHEX-1] = (padv[4*(NHEX-1) +: 4] != 4'd0);
    for (int i = NHEX - 2; i >= 0; i--) begin
      hex_nz[i] = hex_nz[i+1] | (padv[4*i +: 4] != 4'd0);
    end
`endif
    case (last_mode_q)
      MODE_COMP: begin
        disp_glyphs = {NDIG{G_F}};
        for (int i = 0; i < NHEX; i++) begin
          disp_glyphs[7*i +: 7] = glyph(padv[4*i +: 4]);
        end
      end
      MODE_DEC: begin
        for (int i = 0; i < NDIG; i++) begin
          if (dec_show[i]) disp_glyphs[7*i +: 7] = glyph(bcdp[4*i +: 4]);
        end
        for (int i = 1; i < NDIG; i++) begin
          if (neg_q && dec_show[i-1] && !dec_show[i]) disp_glyphs[7*i +: 7] = G_MINUS;
        end
      end
      default: begin
        for (int i = 0; i < NHEX; i++) begin
`ifdef LZ_BLANK_EN
          if (i == 0 || hex_nz[i]) disp_glyphs[7*i +: 7] = glyph(padv[4*i +: 4]);
`else
          disp_glyphs[7*i +: 7] = glyph(padv[4*i +: 4]);
`endif
        end
      end
    endcase
  end

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Next state: synchronisers, key debounce, mode stepping and the conversion FSM
  always_comb begin
    state_d     = state_q;
    sw_meta_d   = sw;
    sw_sync_d   = sw_meta_q;
    key_meta_d  = key_mode;
    key_sync_d  = key_meta_q;
    key_prev_d  = key_sync_q;
    key_db_d    = key_db_q;
    deb_cnt_d   = deb_cnt_q;
    ledr_d      = sw_sync_q;
    mode_d      = mode_q;
    last_mode_d = last_mode_q;
    last_val_d  = last_val_q;
    val_d       = val_q;
    dirty_d     = dirty_q;
    neg_d       = neg_q;
    bcd_d       = bcd_q;
    bit_cnt_d   = bit_cnt_q;
    hex_d       = hex_q;

    if (key_sync_q != key_prev_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_LAST) begin
      deb_cnt_d = deb_cnt_q + DCW'(1);
    end else begin
      key_db_d = key_sync_q;
    end

    // a press is the debounced falling edge; exactly one mode step per press
    if (key_db_q && !key_db_d) begin
      case (mode_q)
        MODE_HEX:  mode_d = MODE_COMP;
        MODE_COMP: mode_d = MODE_DEC;
        default:   mode_d = MODE_HEX;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (dirty_q || (sw_sync_q != last_val_q) || (mode_q != last_mode_q)) begin
          last_val_d  = sw_sync_q;
          last_mode_d = mode_q;
          dirty_d     = 1'b0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        bcd_d     = '0;
        bit_cnt_d = '0;
        neg_d     = 1'b0;
        case (last_mode_q)
          MODE_COMP: begin
            val_d   = ~last_val_q + ONE_W;
            state_d = S_DONE;
          end
          MODE_DEC: begin
            neg_d   = last_val_q[W-1];
            val_d   = last_val_q[W-1] ? (~last_val_q + ONE_W) : last_val_q;
            state_d = S_SHIFT;
          end
          default: begin
            val_d   = last_val_q;
            state_d = S_DONE;
          end
        endcase
      end
      S_SHIFT: begin
        bcd_d     = {bcd_adj[BW-2:0], val_q[W-1]};
        val_d     = {val_q[W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BCW'(1);
        if (bit_cnt_q == BC_LAST) state_d = S_DONE;
      end
      default: begin
        hex_d   = disp_glyphs;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // All state registers; async reset blanks the display and forces a fresh conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      key_meta_q  <= 1'b0;
      key_sync_q  <= 1'b0;
      key_prev_q  <= 1'b0;
      key_db_q    <= 1'b0;
      deb_cnt_q   <= '0;
      ledr_q      <= '0;
      mode_q      <= MODE_HEX;
      last_mode_q <= MODE_HEX;
      last_val_q  <= '0;
      val_q       <= '0;
      dirty_q     <= 1'b1;
      neg_q       <= 1'b0;
      bcd_q       <= '0;
      bit_cnt_q   <= '0;
      busy_q      <= 1'b0;
      hex_q       <= {NDIG{G_BLANK}};
    end else begin
      state_q     <= state_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      key_meta_q  <= key_meta_d;
      key_sync_q  <= key_sync_d;
      key_prev_q  <= key_prev_d;
      key_db_q    <= key_db_d;
      deb_cnt_q   <= deb_cnt_d;
      ledr_q      <= ledr_d;
      mode_q      <= mode_d;
      last_mode_q <= last_mode_d;
      last_val_q  <= last_val_d;
      val_q       <= val_d;
      dirty_q     <= dirty_d;
      neg_q       <= neg_d;
      bcd_q       <= bcd_d;
      bit_cnt_q   <= bit_cnt_d;
      busy_q      <= busy_d;
      hex_q       <= hex_d;
    end
  end

  assign ledr = ledr_q;
  assign hex  = hex_q;
  assign mode = mode_q;
  assign busy = busy_q;

endmodule
